// File: rtl/ahb_matrix_rr.sv
// ahb_matrix_rr: MASTERS x SLAVES AHB-Lite interconnect. Each slave port has
// its own round-robin arbiter with HMASTLOCK hold. Addresses that decode to
// no slave go to an internal per-master default slave.
// Optional feature macro: AHB_MATRIX_DEFSLV_ERR_EN. When defined, the default
// slave answers with a two-cycle ERROR response instead of a one-cycle OKAY.
module ahb_matrix_rr #(
  parameter int                MASTERS       = 4,
  parameter int                SLAVES        = 4,
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA = {DATA_W/4{4'hd}}
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [MASTERS-1:0]        m_addr_req,
  input  logic [MASTERS-1:0]        m_hsel,
  input  logic [MASTERS-1:0]        m_hwrite,
  input  logic [MASTERS-1:0]        m_hmastlock,
  input  logic [2*MASTERS-1:0]      m_htrans,
  input  logic [3*MASTERS-1:0]      m_hsize,
  input  logic [3*MASTERS-1:0]      m_hburst,
  input  logic [4*MASTERS-1:0]      m_hprot,
  input  logic [ADDR_W*MASTERS-1:0] m_haddr,
  input  logic [DATA_W*MASTERS-1:0] m_hwdata,
  output logic [MASTERS-1:0]        m_addr_ack,
  output logic [MASTERS-1:0]        m_data_ack,
  output logic [MASTERS-1:0]        m_hresp,
  output logic [DATA_W*MASTERS-1:0] m_hrdata,
  output logic [SLAVES-1:0]         s_addr_req,
  output logic [SLAVES-1:0]         s_hsel,
  output logic [SLAVES-1:0]         s_hwrite,
  output logic [SLAVES-1:0]         s_hmastlock,
  output logic [2*SLAVES-1:0]       s_htrans,
  output logic [3*SLAVES-1:0]       s_hsize,
  output logic [3*SLAVES-1:0]       s_hburst,
  output logic [4*SLAVES-1:0]       s_hprot,
  output logic [ADDR_W*SLAVES-1:0]  s_haddr,
  output logic [DATA_W*SLAVES-1:0]  s_hwdata,
  input  logic [SLAVES-1:0]         s_addr_ack,
  input  logic [SLAVES-1:0]         s_data_ack,
  input  logic [SLAVES-1:0]         s_hresp,
  input  logic [DATA_W*SLAVES-1:0]  s_hrdata,
  input  logic [ADDR_W*SLAVES-1:0]  S_HADDR_BASE,
  input  logic [ADDR_W*SLAVES-1:0]  S_HADDR_MASK
);

  localparam int MW = $clog2(MASTERS);
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

`ifdef AHB_MATRIX_DEFSLV_ERR_EN
  typedef enum logic [1:0] {D_IDLE, D_DATA, D_ERR1, D_ERR2} dslv_state_e;
`else
  typedef enum logic {D_IDLE, D_DATA} dslv_state_e;
`endif

  logic [MASTERS-1:0] miss;
  logic [MASTERS-1:0] dreq;
  logic [SW-1:0]      tgt [MASTERS];
  logic [MASTERS-1:0] hit [SLAVES];
  logic [SLAVES-1:0]  win_v;
  logic [MW-1:0]      win [SLAVES];

  logic [MW-1:0]      rr_ptr_q [SLAVES], rr_ptr_d [SLAVES];
  logic [MW-1:0]      lock_own_q [SLAVES], lock_own_d [SLAVES];
  logic [MW-1:0]      owner_q [SLAVES], owner_d [SLAVES];
  logic [SLAVES-1:0]  lock_valid_q, lock_valid_d;
  logic [SLAVES-1:0]  dvalid_q, dvalid_d;
  dslv_state_e        dstate_q [MASTERS], dstate_d [MASTERS];

  // Address decode: the lowest-numbered matching slave wins, no match is a miss
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      // NOTE: every combinational output gets a default before any condition so no latch is inferred.
      miss[m] = 1'b1;
      tgt[m]  = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if ((m_haddr[m*ADDR_W +: ADDR_W] & S_HADDR_MASK[s*ADDR_W +: ADDR_W])
            == S_HADDR_BASE[s*ADDR_W +: ADDR_W]) begin
          miss[m] = 1'b0;
          tgt[m]  = SW'(s);
        end
      end
    end
  end

  assign dreq = m_addr_req & miss;

  // Per-slave request vectors
  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      for (int m = 0; m < MASTERS; m++) begin
        hit[s][m] = m_addr_req[m] & ~miss[m] & (tgt[m] == SW'(s));
      end
    end
  end

  // Arbitration: lock owner only while locked, otherwise round-robin after rr_ptr
  always_comb begin
    logic [MW-1:0] cand;
    cand = '0;
    for (int s = 0; s < SLAVES; s++) begin
      win_v[s] = 1'b0;
      win[s]   = '0;
      if (lock_valid_q[s]) begin
        win[s]   = lock_own_q[s];
        win_v[s] = hit[s][lock_own_q[s]];
      end else begin
        // Scanning from the far end lets the nearest requester after rr_ptr win.
        for (int k = MASTERS; k >= 1; k--) begin
          cand = MW'((int'(rr_ptr_q[s]) + k) % MASTERS);
          if (hit[s][cand]) begin
            win_v[s] = 1'b1;
            win[s]   = cand;
          end
        end
      end
    end
  end

  // Slave-side address mux and write-data mux
  always_comb begin
    s_addr_req  = '0;
    s_hsel      = '0;
    s_hwrite    = '0;
    s_hmastlock = '0;
    s_htrans    = '0;
    s_hsize     = '0;
    s_hburst    = '0;
    s_hprot     = '0;
    s_haddr     = '0;
    s_hwdata    = '0;
    for (int s = 0; s < SLAVES; s++) begin
      if (win_v[s]) begin
        s_addr_req[s]              = m_addr_req[win[s]];
        s_hsel[s]                  = m_hsel[win[s]];
        s_hwrite[s]                = m_hwrite[win[s]];
        s_hmastlock[s]             = m_hmastlock[win[s]];
        s_htrans[s*2 +: 2]         = m_htrans[int'(win[s])*2 +: 2];
        s_hsize[s*3 +: 3]          = m_hsize[int'(win[s])*3 +: 3];
        s_hburst[s*3 +: 3]         = m_hburst[int'(win[s])*3 +: 3];
        s_hprot[s*4 +: 4]          = m_hprot[int'(win[s])*4 +: 4];
        s_haddr[s*ADDR_W +: ADDR_W] = m_haddr[int'(win[s])*ADDR_W +: ADDR_W];
      end
      if (dvalid_q[s]) begin
        s_hwdata[s*DATA_W +: DATA_W] = m_hwdata[int'(owner_q[s])*DATA_W +: DATA_W];
      end
    end
  end

  // Master-side accept and response routing, including the default slave
  always_comb begin
    m_addr_ack = '0;
    m_data_ack = '0;
    m_hresp    = '0;
    m_hrdata   = '0;
    for (int m = 0; m < MASTERS; m++) begin
`ifdef AHB_MATRIX_DEFSLV_ERR_EN
      if (dreq[m]) m_addr_ack[m] = (dstate_q[m] != D_ERR1);
`else
      if (dreq[m]) m_addr_ack[m] = 1'b1;
`endif
      case (dstate_q[m])
        D_DATA: begin
          m_data_ack[m]                = 1'b1;
          m_hrdata[m*DATA_W +: DATA_W] = DEFAULT_RDATA;
        end
`ifdef AHB_MATRIX_DEFSLV_ERR_EN
        D_ERR1: m_hresp[m] = 1'b1;
        D_ERR2: begin
          m_data_ack[m]                = 1'b1;
          m_hresp[m]                   = 1'b1;
          m_hrdata[m*DATA_W +: DATA_W] = DEFAULT_RDATA;
        end
`endif
        default: ;
      endcase
      for (int s = 0; s < SLAVES; s++) begin
        if (win_v[s] && int'(win[s]) == m) m_addr_ack[m] = s_addr_ack[s];
        if (dvalid_q[s] && int'(owner_q[s]) == m) begin
          m_data_ack[m] = m_data_ack[m] | s_data_ack[s];
          m_hresp[m]    = m_hresp[m] | s_hresp[s];
          m_hrdata[m*DATA_W +: DATA_W] = m_hrdata[m*DATA_W +: DATA_W]
                                         | s_hrdata[s*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next state: data-phase owner, rr pointer, lock and default-slave FSM
  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      rr_ptr_d[s]     = rr_ptr_q[s];
      lock_own_d[s]   = lock_own_q[s];
      lock_valid_d[s] = lock_valid_q[s];
      owner_d[s]      = owner_q[s];
      dvalid_d[s]     = dvalid_q[s];
      if (s_addr_ack[s]) begin
        // A new address phase replaces the owner even if a data ack coincides.
        owner_d[s]  = win[s];
        dvalid_d[s] = win_v[s];
        if (win_v[s]) begin
          if (m_hmastlock[win[s]]) begin
            lock_valid_d[s] = 1'b1;
            lock_own_d[s]   = win[s];
          end else begin
            rr_ptr_d[s]     = win[s];
            lock_valid_d[s] = 1'b0;
          end
        end
      end else if (s_data_ack[s]) begin
        dvalid_d[s] = 1'b0;
      end
    end
    for (int m = 0; m < MASTERS; m++) begin
      dstate_d[m] = D_IDLE;
`ifdef AHB_MATRIX_DEFSLV_ERR_EN
      if (dstate_q[m] == D_ERR1) dstate_d[m] = D_ERR2;
      else if (dreq[m])          dstate_d[m] = D_ERR1;
`else
      if (dreq[m]) dstate_d[m] = D_DATA;
`endif
    end
  end

  // State registers with asynchronous reset; in-flight data phases are dropped
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      // NOTE: these are control flops, not storage arrays, so every one of them is reset.
      for (int s = 0; s < SLAVES; s++) begin
        rr_ptr_q[s]   <= MW'(MASTERS - 1);
        lock_own_q[s] <= '0;
        owner_q[s]    <= '0;
      end
      lock_valid_q <= '0;
      dvalid_q     <= '0;
      for (int m = 0; m < MASTERS; m++) dstate_q[m] <= D_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      rr_ptr_q     <= rr_ptr_d;
      lock_own_q   <= lock_own_d;
      owner_q      <= owner_d;
      lock_valid_q <= lock_valid_d;
      dvalid_q     <= dvalid_d;
      dstate_q     <= dstate_d;
    end
  end

endmodule

// File: tb/tb_ahb_matrix_rr.sv
// tb_ahb_matrix_rr: directed scenarios followed by random traffic, all checked
// against a transaction-level reference model of the interconnect.
module tb_ahb_matrix_rr;

  localparam int M  = 4;
  localparam int S  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [DW-1:0] DEF = 32'hDDDD_DDDD;
`ifdef AHB_MATRIX_DEFSLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  // Slave 3 overlaps slaves 0..2; the lower index must win there.
  localparam logic [AW*S-1:0] BASE_V = {32'h0000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [AW*S-1:0] MASK_V = {32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic HCLK = 1'b0;
  logic HRESET;
  logic [M-1:0] m_addr_req, m_hsel, m_hwrite, m_hmastlock;
  logic [2*M-1:0] m_htrans;
  logic [3*M-1:0] m_hsize, m_hburst;
  logic [4*M-1:0] m_hprot;
  logic [AW*M-1:0] m_haddr;
  logic [DW*M-1:0] m_hwdata, m_hrdata;
  logic [M-1:0] m_addr_ack, m_data_ack, m_hresp;
  logic [S-1:0] s_addr_req, s_hsel, s_hwrite, s_hmastlock;
  logic [2*S-1:0] s_htrans;
  logic [3*S-1:0] s_hsize, s_hburst;
  logic [4*S-1:0] s_hprot;
  logic [AW*S-1:0] s_haddr, S_HADDR_BASE, S_HADDR_MASK;
  logic [DW*S-1:0] s_hwdata, s_hrdata;
  logic [S-1:0] s_addr_ack, s_data_ack, s_hresp;

  assign S_HADDR_BASE = BASE_V;
  assign S_HADDR_MASK = MASK_V;

  ahb_matrix_rr #(.MASTERS(M), .SLAVES(S), .ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_addr_req(m_addr_req), .m_hsel(m_hsel), .m_hwrite(m_hwrite), .m_hmastlock(m_hmastlock),
    .m_htrans(m_htrans), .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hprot(m_hprot),
    .m_haddr(m_haddr), .m_hwdata(m_hwdata),
    .m_addr_ack(m_addr_ack), .m_data_ack(m_data_ack), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .s_addr_req(s_addr_req), .s_hsel(s_hsel), .s_hwrite(s_hwrite), .s_hmastlock(s_hmastlock),
    .s_htrans(s_htrans), .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot),
    .s_haddr(s_haddr), .s_hwdata(s_hwdata),
    .s_addr_ack(s_addr_ack), .s_data_ack(s_data_ack), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .S_HADDR_BASE(S_HADDR_BASE), .S_HADDR_MASK(S_HADDR_MASK)
  );

  always #5 HCLK = ~HCLK;

  int checks;
  int errors;

  // Reference model: last granted master, lock holder, data-phase owner per
  // slave, and cycles since each master's last accepted unmapped transfer.
  int last_g [S];
  int lock_m [S];
  int dph    [S];
  int dage   [M];
  int tgt_m  [M];
  int win    [S];
  logic [M-1:0]    e_addr_ack, e_data_ack, e_hresp;
  logic [DW*M-1:0] e_hrdata;
  logic [S-1:0]    e_s_req, e_s_sel, e_s_write, e_s_lock;
  logic [2*S-1:0]  e_s_htrans;
  logic [3*S-1:0]  e_s_hsize;
  logic [AW*S-1:0] e_s_haddr;
  logic [DW*S-1:0] e_s_hwdata;

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int target(int m);
    for (int s = 0; s < S; s++)
      if ((m_haddr[m*AW +: AW] & MASK_V[s*AW +: AW]) == BASE_V[s*AW +: AW]) return s;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < S; s++) begin
      last_g[s] = M - 1;
      lock_m[s] = -1;
      dph[s]    = -1;
    end
    for (int m = 0; m < M; m++) dage[m] = 3;
  endtask

  task automatic model_eval();
    int c;
    e_addr_ack = '0; e_data_ack = '0; e_hresp = '0; e_hrdata = '0;
    e_s_req = '0; e_s_sel = '0; e_s_write = '0; e_s_lock = '0;
    e_s_htrans = '0; e_s_hsize = '0; e_s_haddr = '0; e_s_hwdata = '0;
    for (int m = 0; m < M; m++) tgt_m[m] = m_addr_req[m] ? target(m) : -2;
    for (int s = 0; s < S; s++) begin
      win[s] = -1;
      if (lock_m[s] >= 0) begin
        if (tgt_m[lock_m[s]] == s) win[s] = lock_m[s];
      end else begin
        for (int k = 1; k <= M; k++) begin
          c = (last_g[s] + k) % M;
          if (win[s] < 0 && tgt_m[c] == s) win[s] = c;
        end
      end
      if (win[s] >= 0) begin
        e_s_req[s]              = 1'b1;
        e_s_sel[s]              = m_hsel[win[s]];
        e_s_write[s]            = m_hwrite[win[s]];
        e_s_lock[s]             = m_hmastlock[win[s]];
        e_s_htrans[s*2 +: 2]    = m_htrans[win[s]*2 +: 2];
        e_s_hsize[s*3 +: 3]     = m_hsize[win[s]*3 +: 3];
        e_s_haddr[s*AW +: AW]   = m_haddr[win[s]*AW +: AW];
        e_addr_ack[win[s]]      = s_addr_ack[s];
      end
      if (dph[s] >= 0) begin
        e_s_hwdata[s*DW +: DW]  = m_hwdata[dph[s]*DW +: DW];
        e_data_ack[dph[s]]      = e_data_ack[dph[s]] | s_data_ack[s];
        e_hresp[dph[s]]         = e_hresp[dph[s]] | s_hresp[s];
        e_hrdata[dph[s]*DW +: DW] = e_hrdata[dph[s]*DW +: DW] | s_hrdata[s*DW +: DW];
      end
    end
    for (int m = 0; m < M; m++) begin
      if (tgt_m[m] == -1) e_addr_ack[m] = ERR_EN ? (dage[m] != 1) : 1'b1;
      if ((!ERR_EN && dage[m] == 1) || (ERR_EN && dage[m] == 2)) begin
        e_data_ack[m] = 1'b1;
        e_hrdata[m*DW +: DW] = e_hrdata[m*DW +: DW] | DEF;
      end
      if (ERR_EN && (dage[m] == 1 || dage[m] == 2)) e_hresp[m] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int s = 0; s < S; s++) begin
      if (s_addr_ack[s]) begin
        dph[s] = win[s];
        if (win[s] >= 0) begin
          if (m_hmastlock[win[s]]) lock_m[s] = win[s];
          else begin
            last_g[s] = win[s];
            lock_m[s] = -1;
          end
        end
      end else if (s_data_ack[s]) begin
        dph[s] = -1;
      end
    end
    for (int m = 0; m < M; m++) begin
      if (tgt_m[m] == -1 && e_addr_ack[m]) dage[m] = 1;
      else if (dage[m] < 3) dage[m] = dage[m] + 1;
    end
  endtask

  task automatic check_all();
    check("m_addr_ack", m_addr_ack, e_addr_ack);
    check("m_data_ack", m_data_ack, e_data_ack);
    check("m_hresp", m_hresp, e_hresp);
    check("m_hrdata", m_hrdata, e_hrdata);
    check("s_addr_req", s_addr_req, e_s_req);
    check("s_hsel", s_hsel, e_s_sel);
    check("s_hwrite", s_hwrite, e_s_write);
    check("s_hmastlock", s_hmastlock, e_s_lock);
    check("s_htrans", s_htrans, e_s_htrans);
    check("s_hsize", s_hsize, e_s_hsize);
    check("s_haddr", s_haddr, e_s_haddr);
    check("s_hwdata", s_hwdata, e_s_hwdata);
  endtask

  // Inputs are driven 1 ns after the rising edge; outputs are sampled at the falling edge.
  task automatic cycle_check();
    #4;
    model_eval();
    check_all();
  endtask

  task automatic cycle_end();
    model_commit();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_inputs();
    m_addr_req = '0; m_hsel = '0; m_hwrite = '0; m_hmastlock = '0;
    m_htrans = '0; m_hsize = '0; m_hburst = '0; m_hprot = '0;
    m_haddr = '0; m_hwdata = '0;
    s_addr_ack = '0; s_data_ack = '0; s_hresp = '0; s_hrdata = '0;
  endtask

  task automatic set_req(int m, logic [AW-1:0] addr, logic wr, logic lk);
    m_addr_req[m]      = 1'b1;
    m_hsel[m]          = 1'b1;
    m_hwrite[m]        = wr;
    m_hmastlock[m]     = lk;
    m_htrans[m*2 +: 2] = 2'b10;
    m_haddr[m*AW +: AW] = addr;
  endtask

  logic [M-1:0] lk_req [5];
  logic         lk_lock [5];
  logic [M-1:0] lk_exp [5];

  initial begin
    checks = 0;
    errors = 0;
    lk_req  = '{4'b0010, 4'b0001, 4'b0011, 4'b0011, 4'b0001};
    lk_lock = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    lk_exp  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0001};
    clear_inputs();
    HRESET = 1'b1;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Reset state with no requests: every output is zero
    cycle_check();
    check("reset_addr_ack", m_addr_ack, '0);
    check("reset_s_addr_req", s_addr_req, '0);
    check("reset_hrdata", m_hrdata, '0);
    cycle_end();

    // Masters 0,1,2 contend for slave 0: grants rotate 0,1,2,0,1,2
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      for (int m = 0; m < 3; m++) set_req(m, 32'h1000_0000 + 32'(m * 4), 1'b0, 1'b0);
      s_addr_ack = 4'b0001;
      s_data_ack = 4'b0001;
      cycle_check();
      check("rr_grant", m_addr_ack, 256'(1 << (i % 3)));
      cycle_end();
    end

    // Master 1 locks slave 0; master 0 stalls until the unlocking transfer
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      if (lk_req[i][0]) set_req(0, 32'h1000_0010, 1'b1, 1'b0);
      if (lk_req[i][1]) set_req(1, 32'h1000_0020, 1'b1, lk_lock[i]);
      s_addr_ack = 4'b0001;
      s_data_ack = 4'b0001;
      cycle_check();
      check("lock_grant", m_addr_ack, lk_exp[i]);
      cycle_end();
    end

    // Drain, then a read with the slave data ack delayed two cycles
    clear_inputs();
    s_data_ack = '1;
    cycle_check();
    cycle_end();
    clear_inputs();
    set_req(0, 32'h1000_0004, 1'b0, 1'b0);
    s_addr_ack = 4'b0001;
    cycle_check();
    check("rd_addr_ack", m_addr_ack, 4'b0001);
    cycle_end();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      s_hrdata[31:0] = 32'h1234_5678;
      s_data_ack[0]  = (i == 2);
      cycle_check();
      check("rd_data_ack", m_data_ack, (i == 2) ? 4'b0001 : 4'b0000);
      if (i == 2) begin
        check("rd_hrdata_m0", m_hrdata[31:0], 32'h1234_5678);
        check("rd_hrdata_m1", m_hrdata[63:32], '0);
      end
      cycle_end();
    end

    // Master 2 accesses an unmapped address: default slave response
    clear_inputs();
    set_req(2, 32'h9000_0000, 1'b0, 1'b0);
    cycle_check();
    check("dflt_addr_ack", m_addr_ack, 4'b0100);
    cycle_end();
    clear_inputs();
    cycle_check();
    check("dflt_c1_data_ack", m_data_ack, ERR_EN ? 4'b0000 : 4'b0100);
    check("dflt_c1_hresp", m_hresp, ERR_EN ? 4'b0100 : 4'b0000);
    if (!ERR_EN) check("dflt_c1_hrdata", m_hrdata[95:64], DEF);
    cycle_end();
    cycle_check();
    check("dflt_c2_data_ack", m_data_ack, ERR_EN ? 4'b0100 : 4'b0000);
    check("dflt_c2_hresp", m_hresp, ERR_EN ? 4'b0100 : 4'b0000);
    if (ERR_EN) check("dflt_c2_hrdata", m_hrdata[95:64], DEF);
    cycle_end();

    // Reset while slave 0 has a pending data phase
    clear_inputs();
    set_req(0, 32'h1000_0008, 1'b0, 1'b0);
    s_addr_ack = 4'b0001;
    cycle_check();
    cycle_end();
    clear_inputs();
    s_data_ack = 4'b0001;
    cycle_check();
    HRESET = 1'b1;
    #1;
    check("rst_data_ack", m_data_ack, '0);
    model_reset();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    clear_inputs();
    set_req(0, 32'h1000_0000, 1'b0, 1'b0);
    set_req(1, 32'h1000_0000, 1'b0, 1'b0);
    set_req(3, 32'h1000_0000, 1'b0, 1'b0);
    s_addr_ack = 4'b0001;
    cycle_check();
    check("post_rst_grant", m_addr_ack, 4'b0001);
    cycle_end();

    // Random traffic across mapped, overlapping and unmapped regions
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int m = 0; m < M; m++) begin
        if ($urandom_range(0, 3) != 0) begin
          set_req(m, {4'($urandom_range(0, 15)), 28'($urandom)}, 1'($urandom),
                  ($urandom_range(0, 7) == 0));
          m_htrans[m*2 +: 2] = 2'($urandom);
          m_hsize[m*3 +: 3]  = 3'($urandom);
        end
        m_hwdata[m*DW +: DW] = $urandom;
      end
      for (int s = 0; s < S; s++) begin
        s_addr_ack[s]        = ($urandom_range(0, 3) != 0);
        s_data_ack[s]        = 1'($urandom);
        s_hresp[s]           = ($urandom_range(0, 7) == 0);
        s_hrdata[s*DW +: DW] = $urandom;
      end
      cycle_check();
      cycle_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
